// File: rtl/alu_md_pkg.sv
// Shared codes for the ALU/mul-div block: function-select encodings, md_op codes and
// the mul/div sequencer state enum.
package alu_md_pkg;

   typedef enum logic [1:0] {
      GRP_ARITH = 2'b00,
      GRP_LOGIC = 2'b01,
      GRP_SHIFT = 2'b10,
      GRP_CMP   = 2'b11
   } alu_grp_e;

   localparam logic [3:0] LOG_AND = 4'b1000;
   localparam logic [3:0] LOG_OR  = 4'b1110;
   localparam logic [3:0] LOG_XOR = 4'b0110;
   localparam logic [3:0] LOG_NOR = 4'b0001;
   localparam logic [3:0] LOG_A   = 4'b1010;

   localparam logic [1:0] SH_SLL = 2'b00;
   localparam logic [1:0] SH_SRL = 2'b01;
   localparam logic [1:0] SH_SRA = 2'b11;

   localparam logic [2:0] CMP_EQ  = 3'b001;
   localparam logic [2:0] CMP_NE  = 3'b000;
   localparam logic [2:0] CMP_LT  = 3'b010;
   localparam logic [2:0] CMP_LE  = 3'b110;
   localparam logic [2:0] CMP_LTZ = 3'b101;
   localparam logic [2:0] CMP_GTZ = 3'b111;

   localparam logic [1:0] MD_MUL     = 2'b00;
   localparam logic [1:0] MD_MUL_RSV = 2'b01;
   localparam logic [1:0] MD_DIV     = 2'b10;
   localparam logic [1:0] MD_DIV_RSV = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } md_state_e;

endpackage

// File: rtl/alu_md_unit.sv
// Iterative multiply/divide sequencer: magnitudes are iterated one bit per cycle,
// signs are applied when the result is committed to HI/LO.
module md_unit
   import alu_md_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             sign_i,
   input  logic             div_i,
   input  logic             start_i,
   input  logic             hi_we_i,
   input  logic             lo_we_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int unsigned CW = SHW + 1;
   localparam int unsigned W1 = WIDTH + 1;

   md_state_e        state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] a_q, b_q, mag_q, acc_hi_q, acc_lo_q, hi_q, lo_q;
   logic             sign_q, div_q, busy_q, done_q;

   logic [W1-1:0]      mul_sum, div_sh, div_diff;
   logic [WIDTH-1:0]   step_hi, step_lo, res_hi, res_lo;
   logic [2*WIDTH-1:0] prod;
   logic               neg_a, neg_b;

   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic s);
      return (s && v[WIDTH-1]) ? -v : v;
   endfunction

   // One shift-add (mul) or restoring-subtract (div) step on {acc_hi, acc_lo}
   always_comb begin
      mul_sum  = W1'(acc_hi_q) + W1'(acc_lo_q[0] ? mag_q : '0);
      div_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
      div_diff = div_sh - W1'(mag_q);
      if (div_q) begin
         step_hi = div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
         step_lo = {acc_lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
      end else begin
         step_hi = mul_sum[WIDTH:1];
         step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
      end
   end

   // Sign correction and divide-by-zero override for the committed result
   always_comb begin
      neg_a  = sign_q & a_q[WIDTH-1];
      neg_b  = sign_q & b_q[WIDTH-1];
      prod   = {acc_hi_q, acc_lo_q};
      res_hi = acc_hi_q;
      res_lo = acc_lo_q;
      if (!div_q) begin
         if (neg_a ^ neg_b) prod = -prod;
         res_hi = prod[2*WIDTH-1:WIDTH];
         res_lo = prod[WIDTH-1:0];
      end else if (b_q == '0) begin
         res_hi = a_q;
         res_lo = '1;
      end else begin
         res_hi = neg_a ? -acc_hi_q : acc_hi_q;
         res_lo = (neg_a ^ neg_b) ? -acc_lo_q : acc_lo_q;
      end
   end

   // RUN spends WIDTH step cycles plus one commit cycle before DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         mag_q    <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         sign_q   <= 1'b0;
         div_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (hi_we_i) hi_q <= wdata_i;
               if (lo_we_i) lo_q <= wdata_i;
               if (start_i) begin
                  state_q  <= ST_RUN;
                  busy_q   <= 1'b1;
                  cnt_q    <= '0;
                  a_q      <= a_i;
                  b_q      <= b_i;
                  sign_q   <= sign_i;
                  div_q    <= div_i;
                  acc_hi_q <= '0;
                  acc_lo_q <= div_i ? magnitude(a_i, sign_i) : magnitude(b_i, sign_i);
                  mag_q    <= div_i ? magnitude(b_i, sign_i) : magnitude(a_i, sign_i);
               end
            end
            ST_RUN: begin
               if (cnt_q == CW'(WIDTH)) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
                  hi_q    <= res_hi;
                  lo_q    <= res_lo;
               end else begin
                  acc_hi_q <= step_hi;
                  acc_lo_q <= step_lo;
                  cnt_q    <= cnt_q + CW'(1);
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign hi_o   = hi_q;
   assign lo_o   = lo_q;

endmodule

// File: rtl/alu_md.sv
// ALU with combinational add/sub, logic, shift and compare paths, plus an attached
// iterative multiply/divide unit writing the HI/LO registers.
module alu_md
   import alu_md_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Sign,
   input  logic [5:0]       ALUFun,
   output logic [WIDTH-1:0] S,
   output logic             ovf,
   input  logic             md_start,
   input  logic [1:0]       md_op,
   output logic             busy,
   output logic             done,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   logic [WIDTH-1:0] b_eff, add_res, diff, logic_res, shift_res;
   logic             flag_z, flag_n, flag_v, cmp_bit, md_div;
   alu_grp_e         grp;

   // Add/sub result and the subtract flags used by compare
   always_comb begin
      grp     = alu_grp_e'(ALUFun[5:4]);
      b_eff   = ALUFun[0] ? ~B : B;
      add_res = A + b_eff + WIDTH'(ALUFun[0]);
      diff    = A - B;
      flag_z  = (diff == '0);
      flag_n  = diff[WIDTH-1];
      flag_v  = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      ovf     = (grp == GRP_ARITH) && Sign && (A[WIDTH-1] == b_eff[WIDTH-1])
                && (add_res[WIDTH-1] != A[WIDTH-1]);
   end

   always_comb begin
      cmp_bit = 1'b0;
      case (ALUFun[3:1])
         CMP_EQ:  cmp_bit = flag_z;
         CMP_NE:  cmp_bit = ~flag_z;
         CMP_LT:  cmp_bit = flag_n ^ flag_v;
         CMP_LE:  cmp_bit = flag_n | flag_z;
         CMP_LTZ: cmp_bit = flag_n;
         CMP_GTZ: cmp_bit = ~(flag_n | flag_z);
         default: cmp_bit = 1'b0;
      endcase
   end

   always_comb begin
      logic_res = '0;
      case (ALUFun[3:0])
         LOG_AND: logic_res = A & B;
         LOG_OR:  logic_res = A | B;
         LOG_XOR: logic_res = A ^ B;
         LOG_NOR: logic_res = ~(A | B);
         LOG_A:   logic_res = A;
         default: logic_res = '0;
      endcase
   end

   always_comb begin
      shift_res = '0;
      case (ALUFun[1:0])
         SH_SLL:  shift_res = B << A[SHW-1:0];
         SH_SRL:  shift_res = B >> A[SHW-1:0];
         SH_SRA:  shift_res = $signed(B) >>> A[SHW-1:0];
         default: shift_res = '0;
      endcase
   end

   always_comb begin
      S = '0;
      case (grp)
         GRP_ARITH: S = add_res;
         GRP_LOGIC: S = logic_res;
         GRP_SHIFT: S = shift_res;
         GRP_CMP:   S = WIDTH'(cmp_bit);
         default:   S = '0;
      endcase
   end

   // Reserved md_op codes alias onto MUL/DIV
   always_comb begin
      md_div = 1'b0;
      case (md_op)
         MD_MUL, MD_MUL_RSV: md_div = 1'b0;
         MD_DIV, MD_DIV_RSV: md_div = 1'b1;
         default:            md_div = 1'b0;
      endcase
   end

   md_unit #(.WIDTH(WIDTH), .SHW(SHW)) u_md (
      .clk     (clk),
      .rst_n   (rst_n),
      .a_i     (A),
      .b_i     (B),
      .sign_i  (Sign),
      .div_i   (md_div),
      .start_i (md_start),
      .hi_we_i (hi_we),
      .lo_we_i (lo_we),
      .wdata_i (wdata),
      .busy_o  (busy),
      .done_o  (done),
      .hi_o    (hi),
      .lo_o    (lo)
   );

endmodule

// File: tb/tb_alu_md.sv
// Directed self-checking bench for alu_md at WIDTH=32.
module tb_alu_md;

   localparam int unsigned W = 32;

   typedef struct packed {
      logic [5:0]   f;
      logic         sg;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] s;
      logic         v;
   } cvec_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] A, B, S, wdata, hi, lo;
   logic         Sign, ovf, md_start, busy, done, hi_we, lo_we;
   logic [5:0]   ALUFun;
   logic [1:0]   md_op;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_md #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .A(A), .B(B), .Sign(Sign), .ALUFun(ALUFun),
      .S(S), .ovf(ovf), .md_start(md_start), .md_op(md_op), .busy(busy),
      .done(done), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .hi(hi), .lo(lo)
   );

   task automatic do_md(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sg, output int lat);
      @(negedge clk);
      A = a; B = b; Sign = sg; md_op = op; md_start = 1'b1;
      @(posedge clk); #1;
      md_start = 1'b0;
      lat = -1;
      for (int e = 1; e <= 60 && lat < 0; e++) begin
         @(posedge clk); #1;
         if (done === 1'b1) lat = e;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; A = '0; B = '0; Sign = 1'b0; ALUFun = '0; md_start = 1'b0;
      md_op = '0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
      #12;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
      checks++; if (hi !== '0) begin errors++; $display("FAIL reset_hi got %h exp 0", hi); end
      checks++; if (lo !== '0) begin errors++; $display("FAIL reset_lo got %h exp 0", lo); end
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic test_addsub();
      cvec_t tv[7];
      tv = '{'{6'b000000, 1'b0, 32'd1,         32'd2,         32'd3,         1'b0},
             '{6'b000000, 1'b1, 32'h7FFFFFFF,  32'd1,         32'h80000000,  1'b1},
             '{6'b000000, 1'b0, 32'h7FFFFFFF,  32'd1,         32'h80000000,  1'b0},
             '{6'b000001, 1'b1, 32'h80000000,  32'd1,         32'h7FFFFFFF,  1'b1},
             '{6'b000001, 1'b1, 32'd5,         32'd7,         32'hFFFFFFFE,  1'b0},
             '{6'b000000, 1'b1, 32'h80000000,  32'h80000000,  32'h00000000,  1'b1},
             '{6'b000001, 1'b1, 32'h7FFFFFFF,  32'hFFFFFFFF,  32'h80000000,  1'b1}};
      for (int i = 0; i < 7; i++) begin
         ALUFun = tv[i].f; Sign = tv[i].sg; A = tv[i].a; B = tv[i].b; #1;
         checks++; if (S !== tv[i].s) begin errors++; $display("FAIL addsub[%0d] S got %h exp %h", i, S, tv[i].s); end
         checks++; if (ovf !== tv[i].v) begin errors++; $display("FAIL addsub[%0d] ovf got %b exp %b", i, ovf, tv[i].v); end
      end
   endtask

   task automatic test_logic();
      cvec_t tv[7];
      tv = '{'{6'b011000, 1'b0, 32'hF0F000FF, 32'h0FF00F0F, 32'h00F0000F, 1'b0},
             '{6'b011110, 1'b0, 32'hF0F000FF, 32'h0FF00F0F, 32'hFFF00FFF, 1'b0},
             '{6'b010110, 1'b0, 32'hF0F000FF, 32'h0FF00F0F, 32'hFF000FF0, 1'b0},
             '{6'b010001, 1'b0, 32'hF0F000FF, 32'h0FF00F0F, 32'h000FF000, 1'b0},
             '{6'b011010, 1'b0, 32'hF0F000FF, 32'h0FF00F0F, 32'hF0F000FF, 1'b0},
             '{6'b010000, 1'b0, 32'hF0F000FF, 32'h0FF00F0F, 32'h00000000, 1'b0},
             '{6'b011111, 1'b0, 32'hF0F000FF, 32'h0FF00F0F, 32'h00000000, 1'b0}};
      for (int i = 0; i < 7; i++) begin
         ALUFun = tv[i].f; Sign = tv[i].sg; A = tv[i].a; B = tv[i].b; #1;
         checks++; if (S !== tv[i].s) begin errors++; $display("FAIL logic[%0d] S got %h exp %h", i, S, tv[i].s); end
      end
   endtask

   task automatic test_shift();
      cvec_t tv[7];
      tv = '{'{6'b100000, 1'b0, 32'd4,    32'h80000010, 32'h00000100, 1'b0},
             '{6'b100001, 1'b0, 32'd4,    32'h80000010, 32'h08000001, 1'b0},
             '{6'b100011, 1'b0, 32'd4,    32'h80000010, 32'hF8000001, 1'b0},
             '{6'b100010, 1'b0, 32'd4,    32'h80000010, 32'h00000000, 1'b0},
             '{6'b100000, 1'b0, 32'h23,   32'd1,        32'h00000008, 1'b0},
             '{6'b100011, 1'b0, 32'h1F,   32'h7FFFFFFF, 32'h00000000, 1'b0},
             '{6'b100011, 1'b0, 32'h1F,   32'h80000000, 32'hFFFFFFFF, 1'b0}};
      for (int i = 0; i < 7; i++) begin
         ALUFun = tv[i].f; Sign = tv[i].sg; A = tv[i].a; B = tv[i].b; #1;
         checks++; if (S !== tv[i].s) begin errors++; $display("FAIL shift[%0d] S got %h exp %h", i, S, tv[i].s); end
      end
   endtask

   task automatic test_compare();
      cvec_t tv[13];
      tv = '{'{6'b110011, 1'b1, 32'd5,        32'd5,        32'd1, 1'b0},
             '{6'b110001, 1'b1, 32'd5,        32'd5,        32'd0, 1'b0},
             '{6'b110001, 1'b1, 32'd5,        32'd6,        32'd1, 1'b0},
             '{6'b110101, 1'b1, 32'hFFFFFFFF, 32'd1,        32'd1, 1'b0},
             '{6'b110101, 1'b1, 32'h80000000, 32'd1,        32'd1, 1'b0},
             '{6'b110101, 1'b1, 32'd1,        32'hFFFFFFFF, 32'd0, 1'b0},
             '{6'b110101, 1'b1, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b0},
             '{6'b111101, 1'b1, 32'd5,        32'd5,        32'd1, 1'b0},
             '{6'b111101, 1'b1, 32'd6,        32'd5,        32'd0, 1'b0},
             '{6'b111011, 1'b1, 32'hFFFFFFFE, 32'd0,        32'd1, 1'b0},
             '{6'b111111, 1'b1, 32'd1,        32'd0,        32'd1, 1'b0},
             '{6'b111111, 1'b1, 32'd0,        32'd0,        32'd0, 1'b0},
             '{6'b110111, 1'b1, 32'd5,        32'd5,        32'd0, 1'b0}};
      for (int i = 0; i < 13; i++) begin
         ALUFun = tv[i].f; Sign = tv[i].sg; A = tv[i].a; B = tv[i].b; #1;
         checks++; if (S !== tv[i].s) begin errors++; $display("FAIL compare[%0d] S got %h exp %h", i, S, tv[i].s); end
      end
   endtask

   task automatic test_muldiv();
      logic [1:0]   op   [10];
      logic [W-1:0] va   [10];
      logic [W-1:0] vb   [10];
      logic         sg   [10];
      logic [W-1:0] ehi  [10];
      logic [W-1:0] elo  [10];
      int lat;
      op = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11};
      va = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h12345678, 32'd6, 32'hFFFFFFF9,
             32'd5, 32'h80000000, 32'd100, 32'hFFFFFFF0, 32'd42};
      vb = '{32'd7, 32'hFFFFFFFF, 32'h10, 32'd7, 32'd2,
             32'd0, 32'hFFFFFFFF, 32'd7, 32'd0, 32'd6};
      sg = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      ehi = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 32'h0, 32'hFFFFFFFF,
              32'd5, 32'h0, 32'd2, 32'hFFFFFFF0, 32'd0};
      elo = '{32'hFFFFFFEB, 32'h00000001, 32'h23456780, 32'd42, 32'hFFFFFFFD,
              32'hFFFFFFFF, 32'h80000000, 32'd14, 32'hFFFFFFFF, 32'd7};
      for (int i = 0; i < 10; i++) begin
         do_md(op[i], va[i], vb[i], sg[i], lat);
         checks++; if (lat != 33) begin errors++; $display("FAIL md[%0d] latency got %0d exp 33", i, lat); end
         checks++; if (hi !== ehi[i]) begin errors++; $display("FAIL md[%0d] hi got %h exp %h", i, hi, ehi[i]); end
         checks++; if (lo !== elo[i]) begin errors++; $display("FAIL md[%0d] lo got %h exp %h", i, lo, elo[i]); end
         checks++; if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL md[%0d] after_done done=%b busy=%b exp 0 0", i, done, busy);
         end
      end
   endtask

   task automatic test_back_to_back();
      int done_cnt = 0;
      int done_at = -1;
      int busy_bad = 0;
      @(negedge clk);
      A = 32'd3; B = 32'd5; Sign = 1'b0; md_op = 2'b00; md_start = 1'b1;
      @(posedge clk); #1;
      md_start = 1'b0;
      for (int e = 1; e <= 40; e++) begin
         @(negedge clk);
         md_start = (e == 5);
         A = 32'd9; B = 32'd9;
         @(posedge clk); #1;
         if (done === 1'b1) begin done_cnt++; done_at = e; end
         if (e == 33 && busy !== 1'b1) busy_bad++;
         if (e >= 34 && busy !== 1'b0) busy_bad++;
      end
      md_start = 1'b0;
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL b2b done_count got %0d exp 1", done_cnt); end
      checks++; if (done_at != 33) begin errors++; $display("FAIL b2b done_edge got %0d exp 33", done_at); end
      checks++; if (busy_bad != 0) begin errors++; $display("FAIL b2b busy_profile bad_cycles got %0d exp 0", busy_bad); end
      checks++; if (lo !== 32'd15 || hi !== '0) begin
         errors++; $display("FAIL b2b result got %h_%h exp 00000000_0000000f", hi, lo);
      end
   endtask

   task automatic test_hilo();
      int done_at = -1;
      @(negedge clk); hi_we = 1'b1; wdata = 32'hAAAA0001;
      @(negedge clk); hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h55550002;
      @(negedge clk); lo_we = 1'b0;
      checks++; if (hi !== 32'hAAAA0001) begin errors++; $display("FAIL hilo_write hi got %h exp aaaa0001", hi); end
      checks++; if (lo !== 32'h55550002) begin errors++; $display("FAIL hilo_write lo got %h exp 55550002", lo); end
      hi_we = 1'b1; wdata = 32'h77; A = 32'd2; B = 32'd3; Sign = 1'b0; md_op = 2'b00; md_start = 1'b1;
      @(posedge clk); #1;
      hi_we = 1'b0; md_start = 1'b0;
      checks++; if (hi !== 32'h77 || busy !== 1'b1) begin
         errors++; $display("FAIL hilo_with_start hi=%h busy=%b exp 00000077 1", hi, busy);
      end
      for (int e = 1; e <= 40; e++) begin
         @(negedge clk);
         lo_we = (e == 3); wdata = 32'hDEAD;
         @(posedge clk); #1;
         if (e == 3) begin
            checks++; if (lo !== 32'h55550002) begin errors++; $display("FAIL hilo_busy_write lo got %h exp 55550002", lo); end
         end
         if (done === 1'b1) done_at = e;
      end
      lo_we = 1'b0;
      checks++; if (done_at != 33) begin errors++; $display("FAIL hilo_done_edge got %0d exp 33", done_at); end
      checks++; if (hi !== '0 || lo !== 32'd6) begin
         errors++; $display("FAIL hilo_overwrite got %h_%h exp 00000000_00000006", hi, lo);
      end
   endtask

   task automatic test_reset_mid_run();
      int done_seen = 0;
      @(negedge clk); hi_we = 1'b1; wdata = 32'hCAFE;
      @(negedge clk); hi_we = 1'b0;
      A = 32'd3; B = 32'd5; Sign = 1'b0; md_op = 2'b00; md_start = 1'b1;
      @(posedge clk); #1;
      md_start = 1'b0;
      for (int e = 1; e <= 40; e++) begin
         @(negedge clk);
         if (e == 12) rst_n = 1'b1;
         @(posedge clk); #1;
         if (done === 1'b1) done_seen++;
         if (e == 10) begin
            rst_n = 1'b0; #1;
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid busy got %b exp 0", busy); end
            checks++; if (hi !== '0 || lo !== '0) begin
               errors++; $display("FAIL rst_mid hilo got %h_%h exp 0_0", hi, lo);
            end
         end
      end
      checks++; if (done_seen != 0) begin errors++; $display("FAIL rst_mid done_pulses got %0d exp 0", done_seen); end
      checks++; if (hi !== '0 || lo !== '0) begin errors++; $display("FAIL rst_mid_late hilo got %h_%h exp 0_0", hi, lo); end
      @(negedge clk); hi_we = 1'b1; wdata = 32'h1234;
      @(negedge clk); hi_we = 1'b0;
      checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL rst_mid_write hi got %h exp 00001234", hi); end
   endtask

   initial begin
      test_reset();
      test_addsub();
      test_logic();
      test_shift();
      test_compare();
      test_muldiv();
      test_back_to_back();
      test_hilo();
      test_reset_mid_run();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
